// File: rtl/sc_level_pkg.sv
// sc_level_pkg: shared FSM state type and encoding for the level controller.
package sc_level_pkg;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HOLD = 1'b1;
  typedef enum logic {IDLE = ST_IDLE, HOLD = ST_HOLD} state_t;
endpackage

// File: rtl/sc_level_controller_edge.sv
// sc_edge_fall_detect: registered falling-edge detector, previous sample resets to 1 (idle-high button).
module sc_edge_fall_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_fall
);
  logic r_prev;
  always_ff @(posedge clk) r_prev <= rst ? 1'b1 : i_d;
  assign o_fall = r_prev & ~i_d;
endmodule

// File: rtl/sc_level_controller.sv
// sc_level_controller: edge-triggered level up/down with clamp or wrap and a settle window.
// Optional down request path is built only when SC_LEVEL_CTRL_DOWN_EN is defined.
module sc_level_controller
  import sc_level_pkg::*;
#(
  parameter int LEVEL_WIDTH = 4,
  parameter int LEVEL_MAX   = 9,
  parameter int LEVEL_INIT  = 0,
  parameter int WRAP_MODE   = 0,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                   SC_LevelCtrl_CLOCK_50,
  input  logic                   SC_LevelCtrl_RESET_InHigh,
  input  logic                   SC_LevelCtrl_clear_InLow,
  input  logic                   SC_LevelCtrl_load_InLow,
  input  logic [LEVEL_WIDTH-1:0] SC_LevelCtrl_data_InBUS,
  input  logic                   SC_LevelCtrl_up_InLow,
`ifdef SC_LEVEL_CTRL_DOWN_EN
  input  logic                   SC_LevelCtrl_down_InLow,
`endif
  output logic [LEVEL_WIDTH-1:0] SC_LevelCtrl_level_OutBUS,
  output logic                   SC_LevelCtrl_changed_Out,
  output logic                   SC_LevelCtrl_busy_Out,
  output logic                   SC_LevelCtrl_max_Out
);
  localparam int CW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [LEVEL_WIDTH:0]   L_MAX_X = (LEVEL_WIDTH+1)'(LEVEL_MAX);
  localparam logic [LEVEL_WIDTH-1:0] L_MAX   = LEVEL_WIDTH'(LEVEL_MAX);
  localparam logic [LEVEL_WIDTH-1:0] L_INIT  = LEVEL_WIDTH'(LEVEL_INIT);
  localparam logic [CW-1:0]          L_HOLD  = CW'(HOLD_CYCLES - 1);
  state_t r_state, w_state_nx;
  logic [LEVEL_WIDTH-1:0] r_level, w_level_nx, w_load_val, w_up_val, w_dn_val;
  logic [LEVEL_WIDTH:0] w_inc;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic r_changed, w_changed_nx, w_up_req, w_dn_req, w_up_ok, w_dn_ok, w_up_go, w_dn_go;
  sc_edge_fall_detect u_up (
    .clk(SC_LevelCtrl_CLOCK_50), .rst(SC_LevelCtrl_RESET_InHigh),
    .i_d(SC_LevelCtrl_up_InLow), .o_fall(w_up_req)
  );
`ifdef SC_LEVEL_CTRL_DOWN_EN
  sc_edge_fall_detect u_dn (
    .clk(SC_LevelCtrl_CLOCK_50), .rst(SC_LevelCtrl_RESET_InHigh),
    .i_d(SC_LevelCtrl_down_InLow), .o_fall(w_dn_req)
  );
  assign w_dn_ok  = WRAP_MODE != 0 || r_level != '0;
  assign w_dn_val = r_level == '0 ? L_MAX : r_level - 1'b1;
`else
  assign w_dn_req = 1'b0;
  assign w_dn_ok  = 1'b0;
  assign w_dn_val = r_level;
`endif
  // Widened increment so LEVEL_MAX = 2^LEVEL_WIDTH-1 cannot silently overflow
  assign w_inc      = {1'b0, r_level} + 1'b1;
  assign w_up_ok    = WRAP_MODE != 0 || w_inc <= L_MAX_X;
  assign w_up_val   = w_inc > L_MAX_X ? '0 : w_inc[LEVEL_WIDTH-1:0];
  assign w_load_val = {1'b0, SC_LevelCtrl_data_InBUS} > L_MAX_X ? L_MAX : SC_LevelCtrl_data_InBUS;
  assign w_up_go    = w_up_req & ~w_dn_req & w_up_ok;
  assign w_dn_go    = w_dn_req & ~w_up_req & w_dn_ok;
  always_comb begin
    w_state_nx   = r_state;
    w_level_nx   = r_level;
    w_cnt_nx     = r_cnt;
    w_changed_nx = 1'b0;
    if (!SC_LevelCtrl_clear_InLow || !SC_LevelCtrl_load_InLow) begin
      w_level_nx = !SC_LevelCtrl_clear_InLow ? L_INIT : w_load_val;
      w_state_nx = IDLE;
      w_cnt_nx   = '0;
    end else if (r_state == HOLD) begin
      w_state_nx = r_cnt == '0 ? IDLE : HOLD;
      w_cnt_nx   = r_cnt == '0 ? '0 : r_cnt - 1'b1;
    end else if (w_up_go || w_dn_go) begin
      w_level_nx   = w_up_go ? w_up_val : w_dn_val;
      w_changed_nx = 1'b1;
      w_state_nx   = HOLD;
      w_cnt_nx     = L_HOLD;
    end
  end
  always_ff @(posedge SC_LevelCtrl_CLOCK_50) begin
    if (SC_LevelCtrl_RESET_InHigh) begin
      r_state   <= IDLE;
      r_level   <= L_INIT;
      r_cnt     <= '0;
      r_changed <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_level   <= w_level_nx;
      r_cnt     <= w_cnt_nx;
      r_changed <= w_changed_nx;
    end
  end
  assign SC_LevelCtrl_level_OutBUS = r_level;
  assign SC_LevelCtrl_changed_Out  = r_changed;
  assign SC_LevelCtrl_busy_Out     = r_state == HOLD;
  assign SC_LevelCtrl_max_Out      = r_level == L_MAX;
endmodule

// File: tb/tb_sc_level_controller.sv
// tb_sc_level_controller: directed checks on a saturating and a wrapping instance driven in parallel.
module tb_sc_level_controller;
  logic clk = 0, rst = 1, clr_n = 1, ld_n = 1, up_n = 1, dn_n = 1;
  logic [3:0] data = 0;
  logic [3:0] lvl_s, lvl_w;
  logic chg_s, chg_w, busy_s, busy_w, max_s, max_w;
  int n_pass = 0, n_total = 0;
  always #5 clk = ~clk;
  sc_level_controller #(.WRAP_MODE(0)) u_sat (
    .SC_LevelCtrl_CLOCK_50(clk), .SC_LevelCtrl_RESET_InHigh(rst),
    .SC_LevelCtrl_clear_InLow(clr_n), .SC_LevelCtrl_load_InLow(ld_n),
    .SC_LevelCtrl_data_InBUS(data), .SC_LevelCtrl_up_InLow(up_n),
`ifdef SC_LEVEL_CTRL_DOWN_EN
    .SC_LevelCtrl_down_InLow(dn_n),
`endif
    .SC_LevelCtrl_level_OutBUS(lvl_s), .SC_LevelCtrl_changed_Out(chg_s),
    .SC_LevelCtrl_busy_Out(busy_s), .SC_LevelCtrl_max_Out(max_s)
  );
  sc_level_controller #(.WRAP_MODE(1)) u_wrap (
    .SC_LevelCtrl_CLOCK_50(clk), .SC_LevelCtrl_RESET_InHigh(rst),
    .SC_LevelCtrl_clear_InLow(clr_n), .SC_LevelCtrl_load_InLow(ld_n),
    .SC_LevelCtrl_data_InBUS(data), .SC_LevelCtrl_up_InLow(up_n),
`ifdef SC_LEVEL_CTRL_DOWN_EN
    .SC_LevelCtrl_down_InLow(dn_n),
`endif
    .SC_LevelCtrl_level_OutBUS(lvl_w), .SC_LevelCtrl_changed_Out(chg_w),
    .SC_LevelCtrl_busy_Out(busy_w), .SC_LevelCtrl_max_Out(max_w)
  );
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_reset;
    rst = 1;
    tick(2);
    n_total++; if (lvl_s !== 4'd0) $display("FAIL reset_level got %0d want 0", lvl_s); else n_pass++;
    n_total++; if (chg_s !== 1'b0) $display("FAIL reset_changed got %b want 0", chg_s); else n_pass++;
    n_total++; if (busy_s !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_s); else n_pass++;
    n_total++; if (max_s !== 1'b0) $display("FAIL reset_max got %b want 0", max_s); else n_pass++;
    rst = 0;
    tick(1);
  endtask
  task automatic test_up_held;
    int pulses, busies;
    up_n = 0;
    tick(1);
    n_total++; if (lvl_s !== 4'd1) $display("FAIL held_first_level got %0d want 1", lvl_s); else n_pass++;
    n_total++; if (chg_s !== 1'b1) $display("FAIL held_first_changed got %b want 1", chg_s); else n_pass++;
    pulses = int'(chg_s);
    busies = int'(busy_s);
    for (int i = 0; i < 19; i++) begin
      tick(1);
      pulses += int'(chg_s);
      busies += int'(busy_s);
    end
    n_total++; if (pulses != 1) $display("FAIL held_pulses got %0d want 1", pulses); else n_pass++;
    n_total++; if (busies != 4) $display("FAIL held_busy_cycles got %0d want 4", busies); else n_pass++;
    n_total++; if (lvl_s !== 4'd1) $display("FAIL held_final_level got %0d want 1", lvl_s); else n_pass++;
    n_total++; if (lvl_w !== 4'd1) $display("FAIL held_wrap_level got %0d want 1", lvl_w); else n_pass++;
    up_n = 1;
    tick(1);
  endtask
  task automatic test_saturate_wrap;
    ld_n = 0; data = 4'd9;
    tick(1);
    ld_n = 1;
    n_total++; if (lvl_s !== 4'd9) $display("FAIL load9_level got %0d want 9", lvl_s); else n_pass++;
    n_total++; if (chg_s !== 1'b0) $display("FAIL load9_changed got %b want 0", chg_s); else n_pass++;
    tick(1);
    up_n = 0;
    tick(1);
    n_total++; if (lvl_s !== 4'd9) $display("FAIL sat_level got %0d want 9", lvl_s); else n_pass++;
    n_total++; if (chg_s !== 1'b0) $display("FAIL sat_changed got %b want 0", chg_s); else n_pass++;
    n_total++; if (busy_s !== 1'b0) $display("FAIL sat_busy got %b want 0", busy_s); else n_pass++;
    n_total++; if (max_s !== 1'b1) $display("FAIL sat_max got %b want 1", max_s); else n_pass++;
    n_total++; if (lvl_w !== 4'd0) $display("FAIL wrap_level got %0d want 0", lvl_w); else n_pass++;
    n_total++; if (chg_w !== 1'b1) $display("FAIL wrap_changed got %b want 1", chg_w); else n_pass++;
    n_total++; if (busy_w !== 1'b1) $display("FAIL wrap_busy got %b want 1", busy_w); else n_pass++;
    n_total++; if (max_w !== 1'b0) $display("FAIL wrap_max got %b want 0", max_w); else n_pass++;
    up_n = 1;
    tick(5);
  endtask
  task automatic test_back_to_back;
    clr_n = 0;
    tick(1);
    clr_n = 1;
    up_n = 0; tick(1);
    up_n = 1; tick(1);
    up_n = 0; tick(1);
    n_total++; if (chg_s !== 1'b0) $display("FAIL drop_changed got %b want 0", chg_s); else n_pass++;
    n_total++; if (lvl_s !== 4'd1) $display("FAIL drop_level got %0d want 1", lvl_s); else n_pass++;
    up_n = 1; tick(2);
    n_total++; if (busy_s !== 1'b0) $display("FAIL drop_busy_end got %b want 0", busy_s); else n_pass++;
    n_total++; if (lvl_s !== 4'd1) $display("FAIL drop_final_level got %0d want 1", lvl_s); else n_pass++;
    up_n = 0; tick(1);
    up_n = 1; tick(3);
    up_n = 0; tick(1);
    n_total++; if (chg_s !== 1'b0) $display("FAIL edge_last_hold_changed got %b want 0", chg_s); else n_pass++;
    n_total++; if (lvl_s !== 4'd2) $display("FAIL edge_last_hold_level got %0d want 2", lvl_s); else n_pass++;
    up_n = 1; tick(1);
    up_n = 0; tick(1);
    n_total++; if (lvl_s !== 4'd3) $display("FAIL after_idle_level got %0d want 3", lvl_s); else n_pass++;
    up_n = 1; tick(4);
    up_n = 0; tick(1);
    n_total++; if (chg_s !== 1'b1) $display("FAIL first_legal_changed got %b want 1", chg_s); else n_pass++;
    n_total++; if (lvl_s !== 4'd4) $display("FAIL first_legal_level got %0d want 4", lvl_s); else n_pass++;
    up_n = 1; tick(5);
  endtask
  task automatic test_clear_load;
    ld_n = 0; data = 4'd4; tick(1);
    ld_n = 1;
    up_n = 0; tick(1);
    up_n = 1;
    n_total++; if (lvl_s !== 4'd5 || busy_s !== 1'b1) $display("FAIL pre_clear got lvl=%0d busy=%b want lvl=5 busy=1", lvl_s, busy_s); else n_pass++;
    clr_n = 0; tick(1);
    clr_n = 1;
    n_total++; if (lvl_s !== 4'd0) $display("FAIL clear_level got %0d want 0", lvl_s); else n_pass++;
    n_total++; if (busy_s !== 1'b0) $display("FAIL clear_busy got %b want 0", busy_s); else n_pass++;
    n_total++; if (chg_s !== 1'b0) $display("FAIL clear_changed got %b want 0", chg_s); else n_pass++;
    ld_n = 0; data = 4'd12; tick(1);
    ld_n = 1;
    n_total++; if (lvl_s !== 4'd9) $display("FAIL load12_level got %0d want 9", lvl_s); else n_pass++;
    n_total++; if (max_s !== 1'b1) $display("FAIL load12_max got %b want 1", max_s); else n_pass++;
    tick(1);
  endtask
  task automatic test_priority;
    clr_n = 0; ld_n = 0; data = 4'd7; tick(1);
    n_total++; if (lvl_s !== 4'd0) $display("FAIL clear_over_load got %0d want 0", lvl_s); else n_pass++;
    clr_n = 1; tick(1);
    n_total++; if (lvl_s !== 4'd7) $display("FAIL load7_level got %0d want 7", lvl_s); else n_pass++;
    data = 4'd3; up_n = 0; tick(1);
    ld_n = 1;
    n_total++; if (lvl_s !== 4'd3 || chg_s !== 1'b0 || busy_s !== 1'b0) $display("FAIL load_over_up got lvl=%0d chg=%b busy=%b want 3 0 0", lvl_s, chg_s, busy_s); else n_pass++;
    tick(1);
    n_total++; if (lvl_s !== 4'd3 || chg_s !== 1'b0) $display("FAIL held_after_load got lvl=%0d chg=%b want 3 0", lvl_s, chg_s); else n_pass++;
    up_n = 1; tick(1);
  endtask
  task automatic test_reset_mid_hold;
    ld_n = 0; data = 4'd2; tick(1);
    ld_n = 1;
    up_n = 0; tick(1);
    up_n = 1; tick(1);
    rst = 1; tick(1);
    n_total++; if (lvl_s !== 4'd0 || busy_s !== 1'b0 || chg_s !== 1'b0 || max_s !== 1'b0) $display("FAIL mid_hold_reset got lvl=%0d busy=%b chg=%b max=%b want 0 0 0 0", lvl_s, busy_s, chg_s, max_s); else n_pass++;
    rst = 0; tick(1);
    up_n = 0; tick(1);
    n_total++; if (lvl_s !== 4'd1 || chg_s !== 1'b1) $display("FAIL post_reset_up got lvl=%0d chg=%b want 1 1", lvl_s, chg_s); else n_pass++;
    up_n = 1; tick(5);
  endtask
`ifdef SC_LEVEL_CTRL_DOWN_EN
  task automatic test_down;
    ld_n = 0; data = 4'd3; tick(1);
    ld_n = 1;
    up_n = 0; dn_n = 0; tick(1);
    n_total++; if (lvl_s !== 4'd3 || chg_s !== 1'b0 || busy_s !== 1'b0) $display("FAIL simul_req got lvl=%0d chg=%b busy=%b want 3 0 0", lvl_s, chg_s, busy_s); else n_pass++;
    up_n = 1; dn_n = 1; tick(1);
    dn_n = 0; tick(1);
    n_total++; if (lvl_s !== 4'd2 || chg_s !== 1'b1) $display("FAIL down_step got lvl=%0d chg=%b want 2 1", lvl_s, chg_s); else n_pass++;
    dn_n = 1; tick(5);
    clr_n = 0; tick(1);
    clr_n = 1;
    dn_n = 0; tick(1);
    n_total++; if (lvl_s !== 4'd0 || chg_s !== 1'b0) $display("FAIL down_sat got lvl=%0d chg=%b want 0 0", lvl_s, chg_s); else n_pass++;
    n_total++; if (lvl_w !== 4'd9 || chg_w !== 1'b1 || max_w !== 1'b1) $display("FAIL down_wrap got lvl=%0d chg=%b max=%b want 9 1 1", lvl_w, chg_w, max_w); else n_pass++;
    dn_n = 1; tick(5);
  endtask
`endif
  initial begin
    test_reset();
    test_up_held();
    test_saturate_wrap();
    test_back_to_back();
    test_clear_load();
    test_priority();
    test_reset_mid_hold();
`ifdef SC_LEVEL_CTRL_DOWN_EN
    test_down();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
